sbox_substitute: RTL

SBOX_SUBSTITUTE -- requirements
Module: sbox_substitute

---
 rtl/sbox_substitute_pkg.sv | 24 ++
 rtl/sbox_substitute_sbox4.sv | 11 +
 rtl/sbox_substitute.sv | 125 ++++++++++++
 3 files changed

// File: rtl/sbox_substitute_pkg.sv
// Shared definitions for the nibble S-box substitution stage: block width,
// FSM state encoding and the 4-bit S-box table.
package sbox_substitute_pkg;

    localparam int BLOCK_W = 64;
    localparam int NIBBLES = BLOCK_W / 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SUBST = 2'd1,
        MIX   = 2'd2
    } state_e;

    // Entry n is the substitute for input nibble n (index 0 listed first).
    localparam logic [0:15][3:0] SBOX_TABLE = {
        4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
    };

    function automatic logic [3:0] sbox_lookup(input logic [3:0] nib);
        return SBOX_TABLE[nib];
    endfunction

endpackage

// File: rtl/sbox_substitute_sbox4.sv
// Combinational 4-bit S-box; one instance per substitution lane.
module sbox4
    import sbox_substitute_pkg::*;
(
    input  logic [3:0] nib_in,
    output logic [3:0] nib_out
);

    assign nib_out = sbox_lookup(nib_in);

endmodule

// File: rtl/sbox_substitute.sv
// Iterative S-box substitution stage: captures a 64-bit block and round key,
// substitutes LANES nibbles per cycle in ascending nibble order, then XORs
// the substituted block with the key into a held result register.
module sbox_substitute
    import sbox_substitute_pkg::*;
#(
    parameter int LANES = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               set,
    input  logic [0:BLOCK_W-1] data_in,
    input  logic [0:BLOCK_W-1] key,
    output logic               busy,
    output logic               status,
    output logic [0:BLOCK_W-1] data_out
);

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8)) begin : g_bad_lanes
        $error("sbox_substitute: LANES must be 1, 2, 4 or 8");
    end

    // Counter holds the index of the first nibble handled on the current edge.
    localparam logic [3:0] LAST_CNT = 4'(NIBBLES - LANES);
    localparam logic [3:0] CNT_STEP = 4'(LANES);

    state_e             state_q, state_d;
    logic [0:BLOCK_W-1] work_q, work_d;
    logic [0:BLOCK_W-1] key_q, key_d;
    logic [0:BLOCK_W-1] data_out_q, data_out_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               status_q, status_d;
    logic               last_subst;

    logic [3:0] lane_idx [LANES];
    logic [3:0] lane_in  [LANES];
    logic [3:0] lane_out [LANES];

    assign last_subst = (cnt_q == LAST_CNT);

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign lane_idx[g] = cnt_q + 4'(g);
        assign lane_in[g]  = work_q[{lane_idx[g], 2'b00} +: 4];
        sbox4 u_sbox4 (
            .nib_in  (lane_in[g]),
            .nib_out (lane_out[g])
        );
    end

    // State register and datapath registers, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the work and key registers are plain flops, not RAM, so
            // clearing them on reset costs nothing and leaves no stale block.
            state_q    <= IDLE;
            work_q     <= '0;
            key_q      <= '0;
            data_out_q <= '0;
            cnt_q      <= '0;
            status_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge value of every other flop.
            state_q    <= state_d;
            work_q     <= work_d;
            key_q      <= key_d;
            data_out_q <= data_out_d;
            cnt_q      <= cnt_d;
            status_q   <= status_d;
        end
    end

    // Next-state: accept set only in IDLE, stay in SUBST until the last lane group.
    always_comb begin
        // NOTE: default first so no path through the case leaves state_d
        // unassigned and infers a latch.
        state_d = state_q;
        case (state_q)
            IDLE:    if (set) state_d = SUBST;
            SUBST:   if (last_subst) state_d = MIX;
            MIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: capture, in-place substitution, key mix.
    always_comb begin
        work_d     = work_q;
        key_d      = key_q;
        data_out_d = data_out_q;
        cnt_d      = cnt_q;
        status_d   = status_q;
        case (state_q)
            IDLE: begin
                if (set) begin
                    work_d   = data_in;
                    key_d    = key;
                    cnt_d    = '0;
                    status_d = 1'b0;
                end
            end
            SUBST: begin
                for (int l = 0; l < LANES; l++) begin
                    work_d[{lane_idx[l], 2'b00} +: 4] = lane_out[l];
                end
                // Hold on the last group so the counter never wraps back to 0.
                if (!last_subst) cnt_d = cnt_q + CNT_STEP;
            end
            MIX: begin
                data_out_d = work_q ^ key_q;
                status_d   = 1'b1;
            end
            default: ;
        endcase
    end

    // Outputs: busy spans SUBST and MIX, so it drops on the same edge status rises.
    always_comb begin
        busy = (state_q != IDLE);
    end

    assign status   = status_q;
    assign data_out = data_out_q;

endmodule
